// File: rtl/ws2812_frame_arbiter_pkg.sv
// Shared types and defaults for the WS2812 frame arbiter.
// Optional WS2812_BRIGHTNESS_EN adds a per-channel brightness shift.
package ws2812_frame_arbiter_pkg;

    localparam int BITS_PER_LED     = 24;
    localparam int DEF_CLK_MHZ      = 12;
    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_LATCH_CYCLES = DEF_CLK_MHZ * 60;
    localparam int DEF_KICK_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_KICK  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic [7:0] dim8(
        input logic [7:0] c,
        input logic [2:0] s
    );
        return c >> s;
    endfunction

endpackage

// File: rtl/ws2812_frame_arbiter_if.sv
// Source/driver bundle of the WS2812 frame arbiter.
// BRIGHTNESS exists only when WS2812_BRIGHTNESS_EN is defined.
interface ws2812_frame_arbiter_if #(
    parameter int NUM_LEDS = 16
);
    localparam int W = 24 * NUM_LEDS;

    logic [1:0]   REQ;
    logic [W-1:0] RGB0;
    logic [W-1:0] RGB1;
    logic [1:0]   ACK;
    logic         DONE;
    logic         BUSY;
    logic         DRV_RESET;
    logic [W-1:0] DRV_RGB;
`ifdef WS2812_BRIGHTNESS_EN
    logic [2:0]   BRIGHTNESS;

    modport master (
        output REQ, RGB0, RGB1, BRIGHTNESS,
        input  ACK, DONE, BUSY, DRV_RESET, DRV_RGB
    );
    modport slave (
        input  REQ, RGB0, RGB1, BRIGHTNESS,
        output ACK, DONE, BUSY, DRV_RESET, DRV_RGB
    );
`else
    modport master (
        output REQ, RGB0, RGB1,
        input  ACK, DONE, BUSY, DRV_RESET, DRV_RGB
    );
    modport slave (
        input  REQ, RGB0, RGB1,
        output ACK, DONE, BUSY, DRV_RESET, DRV_RGB
    );
`endif
endinterface

// File: rtl/ws2812_frame_arbiter_rr_arb2.sv
// Two-way round-robin pick: contention goes to the source
// that did not win last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       valid
);
    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (req == 2'b11): grant = last ? 2'b01 : 2'b10;
            (req == 2'b01): grant = 2'b01;
            (req == 2'b10): grant = 2'b10;
            default:        grant = 2'b00;
        endcase
    end

    assign valid = |req;
endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Shares one WS2812 driver between two frame sources.
// Define WS2812_BRIGHTNESS_EN to enable the BRIGHTNESS shift.
module ws2812_frame_arbiter
    import ws2812_frame_arbiter_pkg::*;
#(
    parameter int NUM_LEDS     = 16,
    parameter int CLK_MHZ      = DEF_CLK_MHZ,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int LATCH_CYCLES = CLK_MHZ * 60,
    parameter int KICK_CYCLES  = DEF_KICK_CYCLES
) (
    input logic CLK,
    input logic RESET_N,
    ws2812_frame_arbiter_if.slave bus
);
    localparam int W  = BITS_PER_LED * NUM_LEDS;
    localparam int FRAME_CYCLES =
        NUM_LEDS * BITS_PER_LED * BIT_CYCLES + LATCH_CYCLES;
    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam int KW = $clog2(KICK_CYCLES + 1);

    state_t         state_q, state_d;
    logic           sel_q;
    logic           last_q;
    logic [CW-1:0]  cnt_q;
    logic [KW-1:0]  kick_q;
    logic [W-1:0]   rgb_q;
    logic           drv_rst_q;
    logic [1:0]     grant;
    logic           gvalid;
    logic [W-1:0]   pick;
    logic [W-1:0]   load_rgb;

    rr_arb2 u_arb (
        .req   (bus.REQ),
        .last  (last_q),
        .grant (grant),
        .valid (gvalid)
    );

    assign pick = sel_q ? bus.RGB1 : bus.RGB0;

    always_comb begin
        load_rgb = pick;
`ifdef WS2812_BRIGHTNESS_EN
        for (int i = 0; i < NUM_LEDS * 3; i++) begin
            load_rgb[i*8 +: 8] = dim8(pick[i*8 +: 8], bus.BRIGHTNESS);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (gvalid) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_KICK;
            ST_KICK:  if (kick_q == '0) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            kick_q    <= '0;
            rgb_q     <= '0;
            drv_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            // Registered from next state so the pulse spans KICK exactly
            drv_rst_q <= (state_d == ST_KICK);
            if (state_q == ST_IDLE && gvalid) begin
                sel_q <= grant[1];
            end
            if (state_q == ST_LOAD) begin
                rgb_q  <= load_rgb;
                last_q <= sel_q;
                kick_q <= KW'(KICK_CYCLES - 1);
            end
            if (state_q == ST_KICK) begin
                if (kick_q == '0) begin
                    cnt_q <= CW'(FRAME_CYCLES - 1);
                end else begin
                    kick_q <= kick_q - 1'b1;
                end
            end
            if (state_q == ST_SHIFT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign bus.ACK       = (state_q == ST_LOAD) ?
                           (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.DONE      = (state_q == ST_DONE);
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.DRV_RESET = drv_rst_q;
    assign bus.DRV_RGB   = rgb_q;
endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Bench for ws2812_frame_arbiter: timeline model plus directed
// literal checks and a randomized request/frame phase.
module tb_ws2812_frame_arbiter;
    localparam int N     = 2;
    localparam int W     = 48;
    localparam int KICK  = 2;
    localparam int FRAME = N * 24 * 15 + 720;
    localparam int TOTAL = KICK + FRAME + 1;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    ws2812_frame_arbiter_if #(.NUM_LEDS(N)) bus ();

    ws2812_frame_arbiter #(
        .NUM_LEDS     (N),
        .CLK_MHZ      (12),
        .BIT_CYCLES   (15),
        .LATCH_CYCLES (720),
        .KICK_CYCLES  (KICK)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [2:0] eff_b;
`ifdef WS2812_BRIGHTNESS_EN
    logic [2:0] bright = 3'd0;
    assign bus.BRIGHTNESS = bright;
    assign eff_b = bright;
`else
    assign eff_b = 3'd0;
`endif

    // Model: frame timeline measured in cycles since the ACK cycle
    int         age;
    logic       m_sel, m_last, m_hold;
    logic [W-1:0] m_rgb;

    function automatic logic [W-1:0] dimf(logic [W-1:0] f, logic [2:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W / 8; i++) r[i*8 +: 8] = f[i*8 +: 8] >> b;
        return r;
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            age <= -1; m_sel <= 1'b0; m_last <= 1'b1;
            m_hold <= 1'b1; m_rgb <= '0;
        end else begin
            m_hold <= 1'b0;
            if (age < 0) begin
                if (bus.REQ != 2'b00) begin
                    m_sel <= (bus.REQ == 2'b11) ? !m_last : bus.REQ[1];
                    age <= 0;
                end
            end else if (age == 0) begin
                m_rgb  <= dimf(m_sel ? bus.RGB1 : bus.RGB0, eff_b);
                m_last <= m_sel;
                age    <= 1;
            end else if (age == TOTAL) begin
                age <= -1;
            end else begin
                age <= age + 1;
            end
        end
    end

    function automatic logic [52:0] expv();
        logic [1:0] a;
        logic       r;
        a = (age == 0) ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
        r = m_hold || (age >= 1 && age <= KICK);
        return {a, age == TOTAL, age >= 0, r, m_rgb};
    endfunction

    always @(negedge CLK) begin
        logic [52:0] got, e;
        got = {bus.ACK, bus.DONE, bus.BUSY, bus.DRV_RESET, bus.DRV_RGB};
        e = expv();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL model @%0d: ack/done/busy/rst/rgb got %b %b %b %b %h expected %b %b %b %b %h",
                     cyc, got[52:51], got[50], got[49], got[48], got[47:0],
                     e[52:51], e[50], e[49], e[48], e[47:0]);
        end
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_ack(input int lim, output logic [1:0] a,
                            output int at);
        logic seen;
        seen = 1'b0; a = 2'b00; at = -1;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge CLK);
            if (bus.ACK != 2'b00) begin
                seen = 1'b1; a = bus.ACK; at = cyc;
            end
        end
        check("ack_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic wait_idle(input int lim);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < lim && !idle; i++) begin
            @(negedge CLK);
            if (!bus.BUSY) idle = 1'b1;
        end
        check("idle_seen", {63'd0, idle}, 64'd1);
    endtask

    initial begin
        logic [1:0]  a;
        int          at, t0, done_at, nrst, ndone;
        logic [63:0] rnd;
        bus.REQ = 2'b00; bus.RGB0 = '0; bus.RGB1 = '0;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_drv_reset", {63'd0, bus.DRV_RESET}, 64'd1);
        check("rst_busy", {63'd0, bus.BUSY}, 64'd0);
        check("rst_ack", {62'd0, bus.ACK}, 64'd0);
        check("rst_rgb", {16'd0, bus.DRV_RGB}, 64'd0);
        drive_edge(); RESET_N = 1'b1;
        @(negedge CLK);
        check("rel_hold", {63'd0, bus.DRV_RESET}, 64'd1);
        @(negedge CLK);
        check("rel_drv_reset", {63'd0, bus.DRV_RESET}, 64'd0);
        check("rel_busy", {63'd0, bus.BUSY}, 64'd0);

        // Single request, with mid-SHIFT stability check
        drive_edge();
        bus.REQ = 2'b01; bus.RGB0 = 48'h101010_000010;
        t0 = cyc;
        wait_ack(10, a, at);
        check("single_ack", {62'd0, a}, 64'h1);
        check("single_lat", 64'(at - t0), 64'd1);
        drive_edge(); bus.REQ = 2'b00;
        nrst = 0; done_at = -1;
        for (int k = 0; k < 2000 && done_at < 0; k++) begin
            @(negedge CLK);
            if (bus.DRV_RESET) nrst++;
            if (k == 100) bus.RGB0 = '1;
            if (bus.DONE) done_at = cyc;
        end
        check("single_done_lat", 64'(done_at - at), 64'd1443);
        check("single_kick_w", 64'(nrst), 64'd2);
        check("stable_rgb", {16'd0, bus.DRV_RGB}, 64'h101010_000010);
        @(negedge CLK);
        check("post_done_busy", {63'd0, bus.BUSY}, 64'd0);

        // Abort mid-frame at cnt == 700
        drive_edge(); bus.REQ = 2'b01;
        wait_ack(10, a, at);
        drive_edge(); bus.REQ = 2'b00;
        repeat (741) drive_edge();
        RESET_N = 1'b0;
        @(negedge CLK);
        check("abort_drv_reset", {63'd0, bus.DRV_RESET}, 64'd1);
        check("abort_rgb", {16'd0, bus.DRV_RGB}, 64'd0);
        check("abort_busy", {63'd0, bus.BUSY}, 64'd0);
        drive_edge(); drive_edge(); RESET_N = 1'b1;
        ndone = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge CLK);
            if (bus.DONE || bus.ACK != 2'b00) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        drive_edge(); bus.REQ = 2'b10;
        wait_ack(10, a, at);
        check("abort_req10_ack", {62'd0, a}, 64'h2);
        drive_edge(); bus.REQ = 2'b00;
        wait_idle(2000);

        // Contention: alternating grants, a full frame apart
        drive_edge();
        rnd = {$urandom, $urandom}; bus.RGB0 = rnd[47:0];
        rnd = {$urandom, $urandom}; bus.RGB1 = rnd[47:0];
        bus.REQ = 2'b11;
        t0 = -1;
        for (int g = 0; g < 4; g++) begin
            wait_ack(1500, a, at);
            check($sformatf("cont_ack%0d", g), {62'd0, a},
                  (g % 2 == 0) ? 64'h1 : 64'h2);
            if (t0 >= 0) check("cont_gap", 64'(at - t0), 64'd1445);
            t0 = at;
        end
        drive_edge(); bus.REQ = 2'b00;
        wait_idle(2000);

        // Randomized requests and frame changes
        for (int k = 0; k < 12000; k++) begin
            drive_edge();
            if ($urandom_range(0, 7) == 0) bus.REQ = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                rnd = {$urandom, $urandom}; bus.RGB0 = rnd[47:0];
            end
            if ($urandom_range(0, 31) == 0) begin
                rnd = {$urandom, $urandom}; bus.RGB1 = rnd[47:0];
            end
`ifdef WS2812_BRIGHTNESS_EN
            if ($urandom_range(0, 63) == 0) bright = 3'($urandom_range(0, 7));
`endif
        end
        drive_edge(); bus.REQ = 2'b00;
        wait_idle(3000);

        // Brightness shift (or verbatim copy when disabled)
        drive_edge();
`ifdef WS2812_BRIGHTNESS_EN
        bright = 3'd3;
`endif
        bus.RGB1 = {6{8'h80}}; bus.REQ = 2'b10;
        wait_ack(10, a, at);
        drive_edge(); bus.REQ = 2'b00;
        @(negedge CLK);
`ifdef WS2812_BRIGHTNESS_EN
        check("bright_rgb", {16'd0, bus.DRV_RGB}, {16'd0, {6{8'h10}}});
`else
        check("bright_rgb", {16'd0, bus.DRV_RGB}, {16'd0, {6{8'h80}}});
`endif
        wait_idle(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
